// File: rtl/traffic_conflict_monitor.sv
// ---------------------------------------------------------------------------
// traffic_conflict_monitor
//
// Purpose:
//   Watches the lamp outputs of an intersection controller and latches a
//   fault when an unsafe lamp combination persists for PERSIST consecutive
//   clocks. While faulted, the block drives an all-red flash request and
//   records the cause and the controller cycle index at which the fault
//   latched. The fault is sticky. It clears only on an operator request
//   (i_clear) made while the intersection is conflict-free.
//
// Parameters:
//   PERSIST    - consecutive conflicting clocks before a fault latches (1..15)
//   FLASH_HALF - clocks per half-period of o_flash (1..255)
//   CYCLE_MAX  - last controller cycle index before it wraps back to 1
//
// Ports:
//   clk                       - system clock, rising-edge active
//   rst_n                     - asynchronous active-low reset
//   i_start                   - controller run enable; monitoring only while high
//   n_car/s_car/e_car/w_car   - car lamp codes (00 red, 01 green, 10 yellow,
//                               11 turn arrow)
//   n_ped/s_ped/e_ped/w_ped   - pedestrian codes (01 walk, else don't-walk)
//   i_cycle                   - controller cycle index, 1..CYCLE_MAX
//   i_clear                   - operator fault clear, level-sensitive
//   o_fault                   - latched fault flag (high exactly in FAULT)
//   o_flash                   - all-red flash drive, toggling while faulted
//   o_fault_code              - cause of the latched fault
//                               (1 cross, 2 ped, 3 mismatch, 4 cycle)
//   o_fault_cycle             - i_cycle sampled on the fault-latching edge
//   o_state                   - FSM state (00 IDLE, 01 MONITOR, 10 PENDING,
//                               11 FAULT)
//
// Configuration:
//   CYCLE_WATCHDOG_EN - when defined, the block adds a cycle-index watchdog.
//                       A skipped or repeated i_cycle raises code 4, which
//                       latches a fault on the next edge without waiting
//                       PERSIST clocks.
// ---------------------------------------------------------------------------
module traffic_conflict_monitor #(
    parameter int PERSIST    = 2,
    parameter int FLASH_HALF = 4,
    parameter int CYCLE_MAX  = 68
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [1:0] n_car,
    input  logic [1:0] s_car,
    input  logic [1:0] e_car,
    input  logic [1:0] w_car,
    input  logic [1:0] n_ped,
    input  logic [1:0] s_ped,
    input  logic [1:0] e_ped,
    input  logic [1:0] w_ped,
    input  logic [6:0] i_cycle,
    input  logic       i_clear,
    output logic       o_fault,
    output logic       o_flash,
    output logic [2:0] o_fault_code,
    output logic [6:0] o_fault_cycle,
    output logic [1:0] o_state
);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] MONITOR = 2'b01;
    localparam logic [1:0] PENDING = 2'b10;
    localparam logic [1:0] FAULT   = 2'b11;

    localparam logic [3:0] PERSIST_C   = PERSIST[3:0];
    localparam logic [7:0] FLASH_LAST  = 8'(FLASH_HALF - 1);
    localparam logic [6:0] CYCLE_MAX_C = CYCLE_MAX[6:0];

    logic [1:0] state_q,      state_d;
    logic [3:0] persist_q,    persist_d;
    logic [2:0] cand_q,       cand_d;
    logic [2:0] code_q,       code_d;
    logic [6:0] fcycle_q,     fcycle_d;
    logic       flash_q,      flash_d;
    logic [7:0] flash_cnt_q,  flash_cnt_d;
    logic       fault_q,      fault_d;

    logic       ns_active;
    logic       ew_active;
    logic       ns_walk;
    logic       ew_walk;
    logic [2:0] base_code;
    logic [2:0] conflict_code;
    logic       cycle_err;
    logic       go_fault;
    logic [2:0] go_code;
    logic [3:0] persist_inc;

    // Lamp-conflict decode. The lowest-numbered code wins when several
    // conflicts are present at once.
    always_comb begin
        ns_active = (n_car != 2'b00) || (s_car != 2'b00);
        ew_active = (e_car != 2'b00) || (w_car != 2'b00);
        ns_walk   = (n_ped == 2'b01) || (s_ped == 2'b01);
        ew_walk   = (e_ped == 2'b01) || (w_ped == 2'b01);
        base_code = 3'd0;
        if (ns_active && ew_active) begin
            base_code = 3'd1;
        end else if ((ns_walk && ns_active) || (ew_walk && ew_active)) begin
            base_code = 3'd2;
        end else if ((n_car != s_car) || (e_car != w_car)) begin
            base_code = 3'd3;
        end
    end

`ifdef CYCLE_WATCHDOG_EN
    // The history is valid only after one active clock has loaded it. A
    // return to IDLE or a pass through FAULT invalidates it, so the first
    // monitored cycle value after either is accepted unchecked.
    logic [6:0] prev_cycle_q;
    logic       hist_valid_q;
    logic       watch_active;
    logic [6:0] expected_cycle;

    always_comb begin
        watch_active   = i_start && ((state_q == MONITOR) || (state_q == PENDING));
        expected_cycle = (prev_cycle_q >= CYCLE_MAX_C) ? 7'd1 : (prev_cycle_q + 7'd1);
        cycle_err      = watch_active && hist_valid_q && (i_cycle != expected_cycle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_cycle_q <= 7'd0;
            hist_valid_q <= 1'b0;
        end else if (watch_active) begin
            prev_cycle_q <= i_cycle;
            hist_valid_q <= 1'b1;
        end else begin
            hist_valid_q <= 1'b0;
        end
    end
`else
    assign cycle_err = 1'b0;
`endif

    // The watchdog code only shows through when no lamp conflict is present.
    assign conflict_code = (base_code != 3'd0) ? base_code :
                           (cycle_err ? 3'd4 : 3'd0);

    assign persist_inc = persist_q + 4'd1;

    // Next-state logic. Every path into FAULT goes through go_fault so that
    // the cause, the cycle stamp and the flash phase are loaded in one place.
    always_comb begin
        state_d     = state_q;
        persist_d   = persist_q;
        cand_d      = cand_q;
        code_d      = code_q;
        fcycle_d    = fcycle_q;
        flash_d     = flash_q;
        flash_cnt_d = flash_cnt_q;
        go_fault    = 1'b0;
        go_code     = 3'd0;

        case (state_q)
            IDLE: begin
                persist_d = 4'd0;
                if (i_start) begin
                    state_d = MONITOR;
                end
            end
            MONITOR: begin
                if (!i_start) begin
                    state_d   = IDLE;
                    persist_d = 4'd0;
                end else if (conflict_code != 3'd0) begin
                    if ((conflict_code == 3'd4) || (PERSIST_C <= 4'd1)) begin
                        go_fault = 1'b1;
                        go_code  = conflict_code;
                    end else begin
                        state_d   = PENDING;
                        persist_d = 4'd1;
                        cand_d    = conflict_code;
                    end
                end
            end
            PENDING: begin
                if (!i_start) begin
                    state_d   = IDLE;
                    persist_d = 4'd0;
                end else if (conflict_code == 3'd0) begin
                    state_d   = MONITOR;
                    persist_d = 4'd0;
                end else if (conflict_code == 3'd4) begin
                    go_fault = 1'b1;
                    go_code  = 3'd4;
                end else begin
                    persist_d = persist_inc;
                    if (persist_inc >= PERSIST_C) begin
                        go_fault = 1'b1;
                        go_code  = cand_q;
                    end
                end
            end
            default: begin
                // i_start is deliberately ignored while faulted. Only a clean
                // clear request releases the fault.
                if (i_clear && (base_code == 3'd0)) begin
                    state_d     = i_start ? MONITOR : IDLE;
                    code_d      = 3'd0;
                    fcycle_d    = 7'd0;
                    flash_d     = 1'b0;
                    flash_cnt_d = 8'd0;
                end else if (flash_cnt_q == FLASH_LAST) begin
                    flash_d     = ~flash_q;
                    flash_cnt_d = 8'd0;
                end else begin
                    flash_cnt_d = flash_cnt_q + 8'd1;
                end
            end
        endcase

        if (go_fault) begin
            state_d     = FAULT;
            persist_d   = 4'd0;
            code_d      = go_code;
            fcycle_d    = i_cycle;
            flash_d     = 1'b1;
            flash_cnt_d = 8'd0;
        end

        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            persist_q   <= 4'd0;
            cand_q      <= 3'd0;
            code_q      <= 3'd0;
            fcycle_q    <= 7'd0;
            flash_q     <= 1'b0;
            flash_cnt_q <= 8'd0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            persist_q   <= persist_d;
            cand_q      <= cand_d;
            code_q      <= code_d;
            fcycle_q    <= fcycle_d;
            flash_q     <= flash_d;
            flash_cnt_q <= flash_cnt_d;
            fault_q     <= fault_d;
        end
    end

    assign o_fault       = fault_q;
    assign o_flash       = flash_q;
    assign o_fault_code  = code_q;
    assign o_fault_cycle = fcycle_q;
    assign o_state       = state_q;

endmodule

// File: doc/traffic_conflict_monitor.md
TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

Interface
REQ-001 Parameter PERSIST, default 2, meaning consecutive clocks a conflict must hold before it is latched as a fault (legal range 1..15).
REQ-002 Parameter FLASH_HALF, default 4, meaning clocks per half-period of the fault flash output (legal range 1..255).
REQ-003 Parameter CYCLE_MAX, default 68, meaning the last cycle index before the controller wraps to 1.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_start  in  1  controller run enable; monitoring is active only while it is high.
REQ-007 n_car, s_car, e_car, w_car  in  2 each  car lamp code: 00 red, 01 green, 10 yellow, 11 turn arrow.
REQ-008 n_ped, s_ped, e_ped, w_ped  in  2 each  pedestrian code: 00 don't-walk, 01 walk.
REQ-009 i_cycle  in  7  controller cycle index, 1..CYCLE_MAX.
REQ-010 i_clear  in  1  operator fault clear, level-sensitive.
REQ-011 o_fault  out  1  latched fault flag.
REQ-012 o_flash  out  1  all-red flash drive, toggling while faulted.
REQ-013 o_fault_code  out  3  cause of the latched fault.
REQ-014 o_fault_cycle  out  7  i_cycle value sampled on the clock the fault latched.
REQ-015 o_state  out  2  FSM state: 00 IDLE, 01 MONITOR, 10 PENDING, 11 FAULT.

Function
REQ-016 Conflict detection shall be combinational on the current inputs, with priority lowest code first.
- Code 1: (n_car|s_car) != 00 and (e_car|w_car) != 00.
- Code 2: any ped = 01 while the same-axis car code != 00.
- Code 3: n_car != s_car, or e_car != w_car.
- Code 0: no conflict.
REQ-017 IDLE: enter MONITOR when i_start = 1; otherwise stay in IDLE.
REQ-018 MONITOR: on a nonzero conflict code, go to PENDING, load the persist counter with 1, and hold that code as candidate.
REQ-019 PENDING: each clock with any nonzero conflict shall increment the counter; a clock with zero conflict shall return to MONITOR and clear the counter.
REQ-020 When the counter reaches PERSIST, the FSM shall enter FAULT on that edge, latching the candidate code and the i_cycle value.
REQ-021 PERSIST = 1 shall latch FAULT on the first conflicting clock, going directly from MONITOR to FAULT.
REQ-022 i_start = 0 in MONITOR or PENDING shall return the FSM to IDLE and clear the counter; i_start has no effect in FAULT.
REQ-023 FAULT is sticky; it shall exit to MONITOR (or IDLE if i_start = 0) only on a clock where i_clear = 1 and the conflict code = 0.
- i_clear with an active conflict shall be ignored.
REQ-024 On exit from FAULT, o_fault, o_flash, o_fault_code and o_fault_cycle shall clear on the same edge.
REQ-025 In FAULT, o_flash shall start at 1 on the entry edge and toggle every FLASH_HALF clocks; outside FAULT it shall be 0.
REQ-026 o_fault shall equal 1 exactly when o_state = 11; all outputs shall be registered.

Reset
REQ-027 rst_n low shall immediately force IDLE, counter 0, o_fault 0, o_flash 0, o_fault_code 000, o_fault_cycle 0 and the watchdog history 0, independent of clk.
REQ-028 Reset released mid-fault shall not restore the fault; monitoring resumes from IDLE.

Configuration
REQ-029 Macro CYCLE_WATCHDOG_EN shall control an extra fault check on the cycle index.
- Defined: the block registers the previous i_cycle while in MONITOR/PENDING. If i_cycle is neither previous+1 nor 1 after CYCLE_MAX, code 4 becomes active as lowest priority. It bypasses PERSIST and latches FAULT on the next edge.
- The first active clock after IDLE only loads the history and is not checked.
- Undefined: no history register exists, and code 4 is never produced.

Verification
REQ-030 NS green, EW red, peds legal, i_start = 1 for 136 clocks with i_cycle stepping 1..68 twice -> o_fault stays 0, o_state stays 01.
REQ-031 n_car = 01 and e_car = 01 held 2 clocks at i_cycle = 21 -> o_state 11, o_fault_code 001, o_fault_cycle 21, o_flash 1 then toggling every 4 clocks.
REQ-032 A single-clock glitch of n_ped = 01 with n_car = 01 -> PENDING for 1 clock, back to MONITOR, o_fault 0.
REQ-033 In FAULT, assert i_clear with the conflict still present -> stays FAULT; remove the conflict with i_clear = 1 -> MONITOR and all fault outputs 0 on the next edge.
REQ-034 rst_n pulsed low while in FAULT -> outputs 0 immediately without a clock edge; after release with i_start = 1 -> IDLE then MONITOR.
REQ-035 With CYCLE_WATCHDOG_EN defined, i_cycle jumping 30 -> 32 -> code 100 latched on the next edge; without the macro, the same stimulus gives no fault.
